player_cannon: RTL and testbench
================================

Name: player_cannon

Overview:
- Player-side counterpart of the invader formation, on the other end of the projectile interface.
- Moves the player ship and launches the single player projectile consumed by the invader block (projectiles_x/projectiles_y).
- Reads the invader's packed enemy_projectiles_x/enemy_projectiles_y buses, detects hits on the ship, and tracks lives, invulnerability and game over.
- Runs on the game-tick clock clk_4 alongside the invader block.

Parameters:
- SHIP_Y, 450, fixed ship row (pixel y of ship centre).
- X_CENTER, 320, ship x after reset / play deassert.
- X_MIN, 20, leftmost ship x.
- X_MAX, 620, rightmost ship x.
- HALF_W, 10, ship half-width for collision.
- HALF_H, 8, ship half-height for collision.
- PROJ_STEP, 2, player projectile pixels per tick.
- LIVES, 3, lives at start (must be ≤ 3).
- INVULN_TICKS, 63, invulnerability ticks after a hit (≤ 63).

Ports:
- clk_4  in  1  game tick clock, all logic on rising edge
- clr  in  1  reset; one clock; reset is asynchronous and active-low
- play  in  1  game running; 0 forces IDLE re-init
- btn_left  in  1  move left (level)
- btn_right  in  1  move right (level)
- btn_fire  in  1  fire request (rising edge)
- projectile_hit  in  1  invader collision pulse; retires player projectile
- enemy_projectiles_x  in  46  packed enemy shot x
- enemy_projectiles_y  in  45  packed enemy shot y
- ship_x  out  10  ship centre x
- projectiles_x  out  10  player projectile x
- projectiles_y  out  10  player projectile y; 0 = idle
- lives  out  2  remaining lives
- player_hit  out  1  one-tick pulse on accepted hit
- game_over  out  1  high in DEAD
- invuln  out  1  high in HIT

Behaviour:
- Reset (clr=0, async): state=IDLE, ship_x=X_CENTER, projectiles_x=0, projectiles_y=0, lives=LIVES, player_hit=0, game_over=0, invuln=0, fire edge register=0, timer=0.
- Enemy bus unpack: slot k=0..3 has y=enemy_projectiles_y[9k+8:9k] and x=enemy_projectiles_x[9k+8:9k], both 9b zero-extended to 10b. Slot 4 has y=[44:36] (9b) and x=enemy_projectiles_x[45:36] (10b). A slot with y=0 is inactive.
- Hit test per active slot: ey+HALF_H ≥ SHIP_Y, ey ≤ SHIP_Y+HALF_H, ex+HALF_W > ship_x, ex < ship_x+HALF_W.
  - All compares unsigned at 11b; no subtraction, so no underflow.
  - Any number of slots hitting in one tick counts as a single hit.
- States:
  - IDLE: all outputs held at reset values. play=1 → ALIVE next tick.
  - ALIVE: movement, firing, hit test enabled.
    - Accepted hit with lives>1: lives−1, player_hit=1 for one tick, timer=INVULN_TICKS → HIT.
    - Accepted hit with lives=1: lives=0, player_hit pulse → DEAD.
  - HIT: invuln=1; hits ignored; movement allowed; fire blocked; an in-flight projectile keeps moving. timer decrements each tick; timer=0 → ALIVE.
  - DEAD: game_over=1; ship frozen; projectile forced idle (x=y=0); ignores buttons. Leaves only via play=0.
  - Any state with play=0 → IDLE next tick, re-initialising all outputs. This has priority over every other event.
- Movement (ALIVE/HIT), 1 px per tick:
  - left-only and ship_x>X_MIN → ship_x−1.
  - right-only and ship_x<X_MAX → ship_x+1.
  - both or neither pressed → hold.
  - at a limit, saturate; never pass X_MIN/X_MAX.
- Fire: edge = btn_fire & ~btn_fire_q, with btn_fire_q registered every tick.
  - Accepted only in ALIVE with projectiles_y=0: projectiles_x=ship_x, projectiles_y=SHIP_Y−10 (latency 1 tick).
  - Edge while busy or in HIT is dropped, not queued.
- Projectile flight, when projectiles_y≠0:
  - projectile_hit=1 → projectiles_y=0, projectiles_x=0 next tick; takes priority over step.
  - else projectiles_y ≤ PROJ_STEP → 0, idle.
  - else projectiles_y −= PROJ_STEP; x constant.
- Same-tick fire edge and projectile retirement: fire rejected; projectile becomes idle.
- Same-tick hit and play=0: IDLE wins; no player_hit pulse.

Test Plan:
- Reset, play=1, no buttons, 10 ticks → ship_x=320, lives=3, projectiles_y=0, state ALIVE, game_over=0.
- btn_right held 400 ticks from 320 → ship_x climbs 1/tick, saturates at 620; then both buttons held → stays 620.
- Fire edge at ship_x=320 → next tick proj (320,440). After 5 ticks y=430. Second edge while in flight ignored. projectile_hit pulse → y=0 next tick. Free flight from 440 reaches 0 after 220 ticks.
- Enemy slot 2 y=446, x=325 at ship_x=320 → player_hit pulse, lives=2, invuln=1 for 63 ticks. Slot 4 with x=[45:36]=318, y=450 during invuln → no hit.
- Three accepted hits separated by >63 ticks → lives 3→2→1→0, game_over=1, projectile cleared, buttons ignored. play=0 → IDLE, lives=3, ship_x=320.
- Slots 0 and 3 both hitting the same tick → exactly one decrement. Async clr=0 mid-flight → all outputs to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/player_cannon.sv
// Player ship: movement, single projectile, enemy-shot hit detection,
// lives / invulnerability / game-over tracking on the game-tick clock.
module player_cannon #(
  parameter int unsigned SHIP_Y       = 450,
  parameter int unsigned X_CENTER     = 320,
  parameter int unsigned X_MIN        = 20,
  parameter int unsigned X_MAX        = 620,
  parameter int unsigned HALF_W       = 10,
  parameter int unsigned HALF_H       = 8,
  parameter int unsigned PROJ_STEP    = 2,
  parameter int unsigned LIVES        = 3,
  parameter int unsigned INVULN_TICKS = 63
) (
  input  logic        clk_4,
  input  logic        clr,
  input  logic        play,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic        projectile_hit,
  input  logic [45:0] enemy_projectiles_x,
  input  logic [44:0] enemy_projectiles_y,
  output logic [9:0]  ship_x,
  output logic [9:0]  projectiles_x,
  output logic [9:0]  projectiles_y,
  output logic [1:0]  lives,
  output logic        player_hit,
  output logic        game_over,
  output logic        invuln
);

  localparam int unsigned XW    = 10;
  localparam int unsigned CW    = 11;
  localparam int unsigned TW    = 6;
  localparam int unsigned LW    = 2;
  localparam int unsigned SLOTS = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ALIVE = 2'd1;
  localparam logic [1:0] HIT   = 2'd2;
  localparam logic [1:0] DEAD  = 2'd3;

  logic [1:0]    state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          fire_q;
  logic [XW-1:0] ship_n, px_n, py_n;
  logic [LW-1:0] lives_n;
  logic          hit_n, over_n, invuln_n;

  logic [XW-1:0] ex [SLOTS];
  logic [XW-1:0] ey [SLOTS];
  logic [SLOTS-1:0] slot_hit;
  logic          fire_edge, hit_any;

  // Unpack the enemy buses; slot 4 carries a full 10-bit x.
  always_comb begin
    for (int k = 0; k < SLOTS - 1; k++) begin
      ex[k] = XW'(enemy_projectiles_x[9*k +: 9]);
      ey[k] = XW'(enemy_projectiles_y[9*k +: 9]);
    end
    ex[SLOTS-1] = enemy_projectiles_x[45:36];
    ey[SLOTS-1] = XW'(enemy_projectiles_y[44:36]);
  end

  // Box test at 11 bits, written with additions only so nothing underflows.
  always_comb begin
    for (int k = 0; k < SLOTS; k++) begin
      slot_hit[k] = (ey[k] != '0)
                  && (CW'(ey[k]) + CW'(HALF_H) >= CW'(SHIP_Y))
                  && (CW'(ey[k]) <= CW'(SHIP_Y) + CW'(HALF_H))
                  && (CW'(ex[k]) + CW'(HALF_W) > CW'(ship_x))
                  && (CW'(ex[k]) < CW'(ship_x) + CW'(HALF_W));
    end
  end

  assign hit_any   = |slot_hit;
  assign fire_edge = btn_fire & ~fire_q;

  always_comb begin
    state_n = state;
    timer_n = timer;
    ship_n  = ship_x;
    px_n    = projectiles_x;
    py_n    = projectiles_y;
    lives_n = lives;
    hit_n   = 1'b0;

    if (state == ALIVE || state == HIT) begin
      if (btn_left && !btn_right && (CW'(ship_x) > CW'(X_MIN)))
        ship_n = ship_x - XW'(1);
      else if (btn_right && !btn_left && (CW'(ship_x) < CW'(X_MAX)))
        ship_n = ship_x + XW'(1);

      // Retirement beats stepping; a busy projectile also blocks any fire edge.
      if (projectiles_y != '0) begin
        if (projectile_hit || (CW'(projectiles_y) <= CW'(PROJ_STEP))) begin
          px_n = '0;
          py_n = '0;
        end else begin
          py_n = projectiles_y - XW'(PROJ_STEP);
        end
      end else if (state == ALIVE && fire_edge) begin
        px_n = ship_x;
        py_n = XW'(SHIP_Y - 10);
      end
    end

    case (state)
      IDLE: if (play) state_n = ALIVE;
      ALIVE: begin
        if (hit_any) begin
          hit_n = 1'b1;
          if (lives > LW'(1)) begin
            lives_n = lives - LW'(1);
            timer_n = TW'(INVULN_TICKS);
            state_n = HIT;
          end else begin
            lives_n = '0;
            px_n    = '0;
            py_n    = '0;
            state_n = DEAD;
          end
        end
      end
      HIT: begin
        if (timer <= TW'(1)) begin
          timer_n = '0;
          state_n = ALIVE;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      default: begin
        px_n = '0;
        py_n = '0;
      end
    endcase

    // Dropping play re-initialises everything and overrides any same-tick hit.
    if (!play) begin
      state_n = IDLE;
      timer_n = '0;
      ship_n  = XW'(X_CENTER);
      px_n    = '0;
      py_n    = '0;
      lives_n = LW'(LIVES);
      hit_n   = 1'b0;
    end

    over_n   = (state_n == DEAD);
    invuln_n = (state_n == HIT);
  end

  always_ff @(posedge clk_4 or negedge clr) begin
    if (!clr) begin
      state         <= IDLE;
      timer         <= '0;
      fire_q        <= 1'b0;
      ship_x        <= XW'(X_CENTER);
      projectiles_x <= '0;
      projectiles_y <= '0;
      lives         <= LW'(LIVES);
      player_hit    <= 1'b0;
      game_over     <= 1'b0;
      invuln        <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      fire_q        <= btn_fire;
      ship_x        <= ship_n;
      projectiles_x <= px_n;
      projectiles_y <= py_n;
      lives         <= lives_n;
      player_hit    <= hit_n;
      game_over     <= over_n;
      invuln        <= invuln_n;
    end
  end

endmodule

// File: tb/tb_player_cannon.sv
// Directed bench for player_cannon with hand-computed expectations.
module tb_player_cannon;

  logic        clk_4 = 1'b0;
  logic        clr;
  logic        play;
  logic        btn_left, btn_right, btn_fire, projectile_hit;
  logic [45:0] enemy_projectiles_x;
  logic [44:0] enemy_projectiles_y;
  logic [9:0]  ship_x, projectiles_x, projectiles_y;
  logic [1:0]  lives;
  logic        player_hit, game_over, invuln;

  int checks   = 0;
  int failures = 0;

  player_cannon dut (
    .clk_4               (clk_4),
    .clr                 (clr),
    .play                (play),
    .btn_left            (btn_left),
    .btn_right           (btn_right),
    .btn_fire            (btn_fire),
    .projectile_hit      (projectile_hit),
    .enemy_projectiles_x (enemy_projectiles_x),
    .enemy_projectiles_y (enemy_projectiles_y),
    .ship_x              (ship_x),
    .projectiles_x       (projectiles_x),
    .projectiles_y       (projectiles_y),
    .lives               (lives),
    .player_hit          (player_hit),
    .game_over           (game_over),
    .invuln              (invuln)
  );

  always #5 clk_4 = ~clk_4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_4);
      #1;
    end
  endtask

  task automatic clear_enemy();
    enemy_projectiles_x = '0;
    enemy_projectiles_y = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ship_x"}, 32'(ship_x), 32'd320);
    check({tag, "_proj_x"}, 32'(projectiles_x), 32'd0);
    check({tag, "_proj_y"}, 32'(projectiles_y), 32'd0);
    check({tag, "_lives"}, 32'(lives), 32'd3);
    check({tag, "_flags"}, {29'd0, player_hit, game_over, invuln}, 32'd0);
  endtask

  initial begin
    clr = 1'b0; play = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_fire = 1'b0; projectile_hit = 1'b0;
    clear_enemy();
    #12;
    check_reset_outputs("reset");
    @(posedge clk_4); #1;
    clr  = 1'b1;
    play = 1'b1;

    // Idle play, no buttons.
    tick(10);
    check("alive_ship_x", 32'(ship_x), 32'd320);
    check("alive_lives", 32'(lives), 32'd3);
    check("alive_proj_y", 32'(projectiles_y), 32'd0);
    check("alive_flags", {30'd0, game_over, invuln}, 32'd0);

    // Right saturation at X_MAX, then both buttons hold.
    btn_right = 1'b1;
    tick(1);
    check("right_1", 32'(ship_x), 32'd321);
    tick(99);
    check("right_100", 32'(ship_x), 32'd420);
    tick(300);
    check("right_sat", 32'(ship_x), 32'd620);
    btn_left = 1'b1;
    tick(5);
    check("both_hold", 32'(ship_x), 32'd620);
    btn_right = 1'b0;
    tick(300);
    check("left_back", 32'(ship_x), 32'd320);
    btn_left = 1'b0;

    // Fire, flight, ignored second edge, retirement.
    btn_fire = 1'b1;
    tick(1);
    check("fire_x", 32'(projectiles_x), 32'd320);
    check("fire_y", 32'(projectiles_y), 32'd440);
    tick(5);
    check("flight_5", 32'(projectiles_y), 32'd430);
    btn_fire = 1'b0;
    tick(1);
    btn_fire = 1'b1;
    tick(1);
    check("busy_edge_y", 32'(projectiles_y), 32'd426);
    check("busy_edge_x", 32'(projectiles_x), 32'd320);
    projectile_hit = 1'b1;
    tick(1);
    projectile_hit = 1'b0;
    check("retire_y", 32'(projectiles_y), 32'd0);
    check("retire_x", 32'(projectiles_x), 32'd0);

    // Free flight to the top.
    btn_fire = 1'b0;
    tick(1);
    btn_fire = 1'b1;
    tick(1);
    check("refire_y", 32'(projectiles_y), 32'd440);
    tick(219);
    check("flight_219", 32'(projectiles_y), 32'd2);
    tick(1);
    check("flight_done", 32'(projectiles_y), 32'd0);

    // Fire edge coinciding with retirement is dropped.
    btn_fire = 1'b0;
    tick(1);
    btn_fire = 1'b1;
    tick(3);
    btn_fire = 1'b0;
    tick(1);
    btn_fire = 1'b1;
    projectile_hit = 1'b1;
    tick(1);
    projectile_hit = 1'b0;
    check("fire_vs_retire", 32'(projectiles_y), 32'd0);
    tick(1);
    check("fire_vs_retire_2", 32'(projectiles_y), 32'd0);
    btn_fire = 1'b0;

    // Hit from slot 2, then slot 4 ignored during invulnerability.
    enemy_projectiles_y[26:18] = 9'd446;
    enemy_projectiles_x[26:18] = 9'd325;
    tick(1);
    check("hit1_pulse", 32'(player_hit), 32'd1);
    check("hit1_lives", 32'(lives), 32'd2);
    check("hit1_invuln", 32'(invuln), 32'd1);
    clear_enemy();
    enemy_projectiles_x[45:36] = 10'd318;
    enemy_projectiles_y[44:36] = 9'd450;
    tick(1);
    check("invuln_pulse", 32'(player_hit), 32'd0);
    check("invuln_lives", 32'(lives), 32'd2);
    clear_enemy();
    tick(61);
    check("invuln_62", 32'(invuln), 32'd1);
    tick(1);
    check("invuln_63", 32'(invuln), 32'd0);

    // Second hit via slot 4 (full 10-bit x).
    enemy_projectiles_x[45:36] = 10'd318;
    enemy_projectiles_y[44:36] = 9'd450;
    tick(1);
    clear_enemy();
    check("hit2_lives", 32'(lives), 32'd1);
    tick(64);
    check("hit2_recover", 32'(invuln), 32'd0);

    // Final hit with a projectile in flight.
    btn_fire = 1'b1;
    tick(1);
    check("pre_dead_proj", 32'(projectiles_y), 32'd440);
    btn_fire = 1'b0;
    enemy_projectiles_y[8:0] = 9'd450;
    enemy_projectiles_x[8:0] = 9'd320;
    tick(1);
    clear_enemy();
    check("dead_pulse", 32'(player_hit), 32'd1);
    check("dead_lives", 32'(lives), 32'd0);
    check("dead_over", 32'(game_over), 32'd1);
    check("dead_proj", 32'(projectiles_y), 32'd0);
    btn_left = 1'b1;
    btn_fire = 1'b1;
    tick(3);
    check("dead_frozen", 32'(ship_x), 32'd320);
    check("dead_no_fire", 32'(projectiles_y), 32'd0);
    btn_left = 1'b0;
    btn_fire = 1'b0;
    play = 1'b0;
    tick(1);
    check_reset_outputs("replay");

    // Two slots hitting together count once.
    play = 1'b1;
    tick(1);
    enemy_projectiles_y[8:0]   = 9'd450;
    enemy_projectiles_x[8:0]   = 9'd320;
    enemy_projectiles_y[35:27] = 9'd455;
    enemy_projectiles_x[35:27] = 9'd315;
    tick(1);
    clear_enemy();
    check("multi_pulse", 32'(player_hit), 32'd1);
    check("multi_lives", 32'(lives), 32'd2);

    // Async reset mid-flight.
    tick(64);
    btn_right = 1'b1;
    tick(5);
    btn_right = 1'b0;
    btn_fire = 1'b1;
    tick(3);
    check("pre_clr_proj", 32'(projectiles_y), 32'd436);
    #2;
    clr = 1'b0;
    #1;
    check_reset_outputs("async_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
